// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the memory controller.
// The slave view is the arbiter; the master view is everything around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              p0Req;
    logic              p1Req;
    logic              p0Write;
    logic              p1Write;
    logic [ADDR_W-1:0] p0Addr;
    logic [ADDR_W-1:0] p1Addr;
    logic [DATA_W-1:0] p0DataW;
    logic [DATA_W-1:0] p1DataW;
    logic              p0Lock;
    logic              p1Lock;
    logic              p0Ack;
    logic              p1Ack;
    logic [DATA_W-1:0] p0DataR;
    logic [DATA_W-1:0] p1DataR;
    logic              memEnable;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataW;
    logic [DATA_W-1:0] memDataR;
    logic              owner;
    logic              busy;

    modport slave (
        input  p0Req, p1Req, p0Write, p1Write,
        input  p0Addr, p1Addr, p0DataW, p1DataW,
        input  p0Lock, p1Lock, memDataR,
        output p0Ack, p1Ack, p0DataR, p1DataR,
        output memEnable, memWrite, memAddr, memDataW,
        output owner, busy
    );

    modport master (
        output p0Req, p1Req, p0Write, p1Write,
        output p0Addr, p1Addr, p0DataW, p1DataW,
        output p0Lock, p1Lock, memDataR,
        input  p0Ack, p1Ack, p0DataR, p1DataR,
        input  memEnable, memWrite, memAddr, memDataW,
        input  owner, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin memory bus arbiter with bus locking.
// One transaction takes IDLE -> ACCESS -> RESP, ack pulses in RESP.
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic               CLK,
    input logic               RESET,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } stateT;

    stateT             state;
    logic              lastOwner;
    logic              owner;
    logic              lockActive;
    logic              respRead;
    logic              ack0;
    logic              ack1;
    logic              memEnable;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataW;
    logic [DATA_W-1:0] dataR0;
    logic [DATA_W-1:0] dataR1;

    logic              ownerLock;
    logic              lockHold;
    logic              elig0;
    logic              elig1;
    logic              winner;
    logic              winWrite;
    logic              winLock;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winDataW;

    assign ownerLock = owner ? bus.p1Lock : bus.p0Lock;
    assign lockHold  = lockActive && ownerLock;
    assign elig0     = bus.p0Req && !(lockHold && owner);
    assign elig1     = bus.p1Req && !(lockHold && !owner);

    // Round-robin pick: a lone request wins, a tie goes away from lastOwner.
    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (elig0 && elig1):  winner = ~lastOwner;
            (elig1 && !elig0): winner = 1'b1;
            default:           winner = 1'b0;
        endcase
    end

    assign winWrite = winner ? bus.p1Write : bus.p0Write;
    assign winLock  = winner ? bus.p1Lock  : bus.p0Lock;
    assign winAddr  = winner ? bus.p1Addr  : bus.p0Addr;
    assign winDataW = winner ? bus.p1DataW : bus.p0DataW;

    // Transaction FSM; memory strobes are registered at grant so they are
    // valid for the whole ACCESS cycle and zero everywhere else.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            lastOwner  <= 1'b1;
            owner      <= 1'b0;
            lockActive <= 1'b0;
            respRead   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            memEnable  <= 1'b0;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memDataW   <= '0;
            dataR0     <= '0;
            dataR1     <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            memEnable <= 1'b0;
            memWrite  <= 1'b0;
            memAddr   <= '0;
            memDataW  <= '0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        owner      <= winner;
                        lastOwner  <= winner;
                        lockActive <= winLock;
                        respRead   <= !winWrite;
                        memEnable  <= 1'b1;
                        memWrite   <= winWrite;
                        memAddr    <= winAddr;
                        memDataW   <= winDataW;
                        state      <= ACCESS;
                    end else if (lockActive && !ownerLock) begin
                        lockActive <= 1'b0;
                    end
                end
                ACCESS: begin
                    ack0  <= !owner;
                    ack1  <= owner;
                    state <= RESP;
                end
                RESP: begin
                    if (respRead) begin
                        if (owner) dataR1 <= bus.memDataR;
                        else       dataR0 <= bus.memDataR;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p0Ack     = ack0;
    assign bus.p1Ack     = ack1;
    assign bus.p0DataR   = (ack0 && respRead) ? bus.memDataR : dataR0;
    assign bus.p1DataR   = (ack1 && respRead) ? bus.memDataR : dataR1;
    assign bus.memEnable = memEnable;
    assign bus.memWrite  = memWrite;
    assign bus.memAddr   = memAddr;
    assign bus.memDataW  = memDataW;
    assign bus.owner     = owner;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small RAM model and
// a scoreboard of expected acks checked by a negedge monitor.
module tb_mem_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic        id;
        logic        isRead;
        logic [15:0] data;
    } expT;

    expT sb[$];
    expT cur;
    int  checks = 0;
    int  errors = 0;

    logic [15:0] ram [0:255] = '{8'h10: 16'hBEEF, default: 16'h0000};

    // RAM: read data appears the cycle after the access cycle.
    always @(posedge CLK) begin
        if (bus.memEnable) begin
            if (bus.memWrite) ram[bus.memAddr[7:0]] <= bus.memDataW;
            else bus.memDataR <= ram[bus.memAddr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Every ack pops one expected transaction.
    always @(negedge CLK) begin
        if (bus.p0Ack === 1'b1 || bus.p1Ack === 1'b1) begin
            check("ack_excl", 32'(bus.p0Ack & bus.p1Ack), 32'(0));
            check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                check("ack_id", 32'(bus.p1Ack), 32'(cur.id));
                if (cur.isRead)
                    check("read_data",
                          32'(cur.id ? bus.p1DataR : bus.p0DataR),
                          32'(cur.data));
            end
        end
    end

    initial begin
        bus.p0Req = 0; bus.p1Req = 0;
        bus.p0Write = 0; bus.p1Write = 0;
        bus.p0Addr = '0; bus.p1Addr = '0;
        bus.p0DataW = '0; bus.p1DataW = '0;
        bus.p0Lock = 0; bus.p1Lock = 0;
        tick(); tick();
        check("rst_memEnable", 32'(bus.memEnable), 32'(0));
        check("rst_memWrite", 32'(bus.memWrite), 32'(0));
        check("rst_memAddr", 32'(bus.memAddr), 32'(0));
        check("rst_memDataW", 32'(bus.memDataW), 32'(0));
        check("rst_owner", 32'(bus.owner), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_acks", 32'({bus.p0Ack, bus.p1Ack}), 32'(0));
        check("rst_p0DataR", 32'(bus.p0DataR), 32'(0));
        check("rst_p1DataR", 32'(bus.p1DataR), 32'(0));
        RESET = 0;
        tick();

        // p0 read of 0x0010
        bus.p0Req = 1; bus.p0Write = 0; bus.p0Addr = 16'h0010;
        sb.push_back('{id: 1'b0, isRead: 1'b1, data: 16'hBEEF});
        tick();
        check("rd_memEnable", 32'(bus.memEnable), 32'(1));
        check("rd_memAddr", 32'(bus.memAddr), 32'h0010);
        check("rd_memWrite", 32'(bus.memWrite), 32'(0));
        check("rd_busy", 32'(bus.busy), 32'(1));
        tick();
        check("rd_p0Ack", 32'(bus.p0Ack), 32'(1));
        check("rd_p0DataR", 32'(bus.p0DataR), 32'hBEEF);
        check("rd_resp_memEnable", 32'(bus.memEnable), 32'(0));
        bus.p0Req = 0;
        tick();
        check("rd_hold", 32'(bus.p0DataR), 32'hBEEF);
        check("rd_ack_low", 32'(bus.p0Ack), 32'(0));
        check("rd_idle_busy", 32'(bus.busy), 32'(0));

        // p1 write 0x1234 to 0x0020, then p0 reads it back
        bus.p1Req = 1; bus.p1Write = 1;
        bus.p1Addr = 16'h0020; bus.p1DataW = 16'h1234;
        sb.push_back('{id: 1'b1, isRead: 1'b0, data: 16'h0});
        tick();
        check("wr_memEnable", 32'(bus.memEnable), 32'(1));
        check("wr_memWrite", 32'(bus.memWrite), 32'(1));
        check("wr_memAddr", 32'(bus.memAddr), 32'h0020);
        check("wr_memDataW", 32'(bus.memDataW), 32'h1234);
        check("wr_owner", 32'(bus.owner), 32'(1));
        tick();
        check("wr_p1Ack", 32'(bus.p1Ack), 32'(1));
        check("wr_p1DataR", 32'(bus.p1DataR), 32'(0));
        bus.p1Req = 0; bus.p1Write = 0;
        tick();
        check("idle_memWrite", 32'(bus.memWrite), 32'(0));
        check("idle_memDataW", 32'(bus.memDataW), 32'(0));
        bus.p0Req = 1; bus.p0Addr = 16'h0020;
        sb.push_back('{id: 1'b0, isRead: 1'b1, data: 16'h1234});
        tick(); tick();
        check("rb_p0DataR", 32'(bus.p0DataR), 32'h1234);
        bus.p0Req = 0;
        tick();

        // both requesting from reset: p0,p1,p0,p1
        RESET = 1;
        tick();
        RESET = 0;
        bus.p0Addr = 16'h0010; bus.p1Addr = 16'h0020;
        bus.p0Req = 1; bus.p1Req = 1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{id: 1'b0, isRead: 1'b1, data: 16'hBEEF});
            sb.push_back('{id: 1'b1, isRead: 1'b1, data: 16'h1234});
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("rr_p0Ack", 32'(bus.p0Ack), 32'(i == 2 || i == 8));
            check("rr_p1Ack", 32'(bus.p1Ack), 32'(i == 5 || i == 11));
        end
        bus.p0Req = 0; bus.p1Req = 0;
        tick();

        // p1 locks the bus for 4 transactions while p0 waits
        bus.p1Req = 1; bus.p1Lock = 1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{id: 1'b1, isRead: 1'b1, data: 16'h1234});
        sb.push_back('{id: 1'b0, isRead: 1'b1, data: 16'hBEEF});
        sb.push_back('{id: 1'b1, isRead: 1'b1, data: 16'h1234});
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("lk_p0Ack", 32'(bus.p0Ack), 32'(i == 14));
            check("lk_p1Ack", 32'(bus.p1Ack),
                  32'(i == 2 || i == 5 || i == 8 || i == 11 || i == 17));
            if (i == 13) check("lk_owner_after", 32'(bus.owner), 32'(0));
            if (i == 1) bus.p0Req = 1;
            if (i == 11) bus.p1Lock = 0;
            if (i == 14) bus.p0Req = 0;
            if (i == 17) bus.p1Req = 0;
        end
        tick();

        // reset in ACCESS abandons the transaction
        bus.p1Req = 1;
        tick();
        check("ra_pre_memEnable", 32'(bus.memEnable), 32'(1));
        RESET = 1;
        #1;
        check("ra_memEnable", 32'(bus.memEnable), 32'(0));
        check("ra_memAddr", 32'(bus.memAddr), 32'(0));
        check("ra_busy", 32'(bus.busy), 32'(0));
        check("ra_owner", 32'(bus.owner), 32'(0));
        check("ra_p1DataR", 32'(bus.p1DataR), 32'(0));
        tick();
        check("ra_no_ack", 32'({bus.p0Ack, bus.p1Ack}), 32'(0));
        RESET = 0;
        sb.push_back('{id: 1'b1, isRead: 1'b1, data: 16'h1234});
        tick();
        check("ra_regrant", 32'(bus.memEnable), 32'(1));
        check("ra_regrant_owner", 32'(bus.owner), 32'(1));
        tick();
        check("ra_p1Ack", 32'(bus.p1Ack), 32'(1));
        bus.p1Req = 0;
        tick();
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
